// File: rtl/fm_rd_arb_pkg.sv
// fm_rd_arb_pkg
//   Shared constants, arbiter state encoding and the round-robin pick helper
//   for the four-port DRAM read-command arbiter.
package fm_rd_arb_pkg;

   // Default interface widths of the internal bus.
   localparam int C_IB_ADDR_WIDTH = 32;
   localparam int C_IB_LEN_WIDTH  = 8;
   localparam int C_IB_DATA_WIDTH = 32;

   // Number of requesters; the id field of a FIFO entry is sized for this.
   localparam int P_ARB_NREQ = 4;

   typedef enum logic {
      P_ARB_IDLE  = 1'b0,
      P_ARB_GRANT = 1'b1
   } arb_state_e;

   // First set request at or after ptr, wrapping 3 -> 0.
   // Returns ptr when nothing is set; callers only use it with |req.
   function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                          input logic [1:0] ptr);
      logic [1:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < P_ARB_NREQ; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/fm_rd_arb_fifo.sv
// fm_rd_arb_fifo
//   Outstanding-command FIFO: one entry {id[1:0], len} per accepted command.
//   Synchronous, single clock, read data is the head entry (show-ahead).
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   push_i, wdata_i    write request / entry (ignored while full)
//   pop_i              drop the head entry (ignored while empty)
//   rdata_o            head entry, valid while !empty_o
//   full_o, empty_o    occupancy flags
module fm_rd_arb_fifo #(
   parameter int P_W     = 10,
   parameter int P_DEPTH = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           push_i,
   input  logic [P_W-1:0] wdata_i,
   input  logic           pop_i,
   output logic [P_W-1:0] rdata_o,
   output logic           full_o,
   output logic           empty_o
);

   localparam int AW = $clog2(P_DEPTH);

   logic [P_W-1:0] mem_q [P_DEPTH];
   // Pointers carry one wrap bit so full and empty are distinguishable.
   logic [AW:0]    wr_q, rd_q;
   logic           do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/fm_rd_arb.sv
// fm_rd_arb
//   Four-port round-robin read-command arbiter in front of the shared DRAM
//   read path. One requester is granted at a time and the grant is held until
//   the downstream accepts. Every accepted command's {owner, len} is queued;
//   returning read beats are steered back to the owner in command order.
// Ports
//   clk_core, rst_x         clock, synchronous active-high reset
//   i_req/i_adrs/i_len      per-requester command (slice n = requester n)
//   o_ack                   per-requester command accept
//   o_req/o_adrs/o_len      downstream command, i_ack its accept
//   i_strr/i_dbr            downstream read beat strobe / data
//   o_strr/o_dbr            per-requester beat strobe / broadcast data
//   o_err                   sticky: beat arrived with nothing outstanding
module fm_rd_arb
   import fm_rd_arb_pkg::*;
#(
   parameter int P_IB_ADDR_WIDTH = C_IB_ADDR_WIDTH,
   parameter int P_IB_LEN_WIDTH  = C_IB_LEN_WIDTH,
   parameter int P_IB_DATA_WIDTH = C_IB_DATA_WIDTH,
   parameter int P_OUT_DEPTH     = 4
) (
   input  logic                         clk_core,
   input  logic                         rst_x,
   input  logic [3:0]                   i_req,
   input  logic [4*P_IB_ADDR_WIDTH-1:0] i_adrs,
   input  logic [4*P_IB_LEN_WIDTH-1:0]  i_len,
   output logic [3:0]                   o_ack,
   output logic                         o_req,
   output logic [P_IB_ADDR_WIDTH-1:0]   o_adrs,
   output logic [P_IB_LEN_WIDTH-1:0]    o_len,
   input  logic                         i_ack,
   input  logic                         i_strr,
   input  logic [P_IB_DATA_WIDTH-1:0]   i_dbr,
   output logic [3:0]                   o_strr,
   output logic [P_IB_DATA_WIDTH-1:0]   o_dbr,
   output logic                         o_err
);

   localparam int AW = P_IB_ADDR_WIDTH;
   localparam int LW = P_IB_LEN_WIDTH;
   localparam int EW = 2 + LW;

   arb_state_e    state_q, state_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [LW-1:0] cnt_q, cnt_d, cnt_eff;
   logic          cnt_vld_q, cnt_vld_d;
   logic          err_q;

   logic          fifo_full, fifo_empty, push, pop;
   logic [EW-1:0] head;
   logic [1:0]    head_id;
   logic [LW-1:0] head_len;

   fm_rd_arb_fifo #(
      .P_W     (EW),
      .P_DEPTH (P_OUT_DEPTH)
   ) u_fifo (
      .clk_i   (clk_core),
      .rst_i   (rst_x),
      .push_i  (push),
      .wdata_i ({gnt_q, o_len}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Granted slices pass straight through; only meaningful while o_req.
   assign o_adrs = i_adrs[gnt_q*AW +: AW];
   assign o_len  = i_len[gnt_q*LW +: LW];

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      o_req   = 1'b0;
      o_ack   = '0;
      push    = 1'b0;
      case (state_q)
         P_ARB_IDLE: begin
            if (|i_req && !fifo_full) begin
               gnt_d   = rr_pick(i_req, ptr_q);
               state_d = P_ARB_GRANT;
            end
         end
         P_ARB_GRANT: begin
            o_req = i_req[gnt_q] & ~fifo_full;
            if (o_req && i_ack) begin
               o_ack[gnt_q] = 1'b1;
               push         = 1'b1;
               ptr_d        = gnt_q + 2'd1;
               state_d      = P_ARB_IDLE;
            end else if (!i_req[gnt_q]) begin
               // Requester withdrew before acceptance.
               state_d = P_ARB_IDLE;
            end
         end
         default: state_d = P_ARB_IDLE;
      endcase
   end

   // Return path. The counter is loaded from the head in its first cycle;
   // until then the head's len stands in for it so a beat arriving in that
   // same cycle is counted correctly.
   assign head_id  = head[EW-1 -: 2];
   assign head_len = head[LW-1:0];
   assign cnt_eff  = cnt_vld_q ? cnt_q : head_len;
   assign o_dbr    = i_dbr;
   assign o_err    = err_q;

   always_comb begin
      o_strr    = '0;
      cnt_d     = cnt_q;
      cnt_vld_d = cnt_vld_q;
      if (i_strr && !fifo_empty) o_strr[head_id] = 1'b1;
      // Last beat pops; a zero-length head pops once its count is loaded.
      pop = ~fifo_empty & ((cnt_vld_q & (cnt_q == '0)) |
                           (i_strr & (cnt_eff == LW'(1))));
      if (pop) begin
         cnt_vld_d = 1'b0;
      end else if (!fifo_empty) begin
         cnt_vld_d = 1'b1;
         cnt_d     = (i_strr && cnt_eff != '0) ? cnt_eff - LW'(1) : cnt_eff;
      end
   end

   always_ff @(posedge clk_core) begin
      if (rst_x) begin
         state_q   <= P_ARB_IDLE;
         gnt_q     <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         cnt_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         cnt_vld_q <= cnt_vld_d;
         err_q     <= err_q | (i_strr & fifo_empty);
      end
   end

endmodule

// File: tb/tb_fm_rd_arb.sv
// tb_fm_rd_arb
//   Directed scenarios plus a randomized phase. The stimulus process drives
//   requesters, the downstream accept and read beats; a separate monitor keeps
//   a reference model (round-robin pointer, beat owner queue, outstanding
//   count, sticky error) and compares DUT outputs every cycle.
module tb_fm_rd_arb;

   localparam int AW    = 32;
   localparam int LW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic            clk_core = 1'b0;
   logic            rst_x    = 1'b1;
   logic [3:0]      i_req;
   logic [4*AW-1:0] i_adrs;
   logic [4*LW-1:0] i_len;
   logic [3:0]      o_ack;
   logic            o_req;
   logic [AW-1:0]   o_adrs;
   logic [LW-1:0]   o_len;
   logic            i_ack;
   logic            i_strr;
   logic [DW-1:0]   i_dbr;
   logic [3:0]      o_strr;
   logic [DW-1:0]   o_dbr;
   logic            o_err;

   fm_rd_arb #(
      .P_IB_ADDR_WIDTH (AW),
      .P_IB_LEN_WIDTH  (LW),
      .P_IB_DATA_WIDTH (DW),
      .P_OUT_DEPTH     (DEPTH)
   ) dut (
      .clk_core (clk_core),
      .rst_x    (rst_x),
      .i_req    (i_req),
      .i_adrs   (i_adrs),
      .i_len    (i_len),
      .o_ack    (o_ack),
      .o_req    (o_req),
      .o_adrs   (o_adrs),
      .o_len    (o_len),
      .i_ack    (i_ack),
      .i_strr   (i_strr),
      .i_dbr    (i_dbr),
      .o_strr   (o_strr),
      .o_dbr    (o_dbr),
      .o_err    (o_err)
   );

   always #5 clk_core = ~clk_core;

   int vec  = 0;
   int miss = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Round-robin rule: first pending requester at or after ptr, wrapping.
   function automatic int rr_ref(input logic [3:0] req, input int ptr);
      for (int k = 0; k < 4; k++)
         if (req[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   // ---------------- stimulus state ----------------
   logic [3:0]    req_v;
   logic [AW-1:0] c_adrs [4];
   logic [LW-1:0] c_len  [4];
   int owed, ack_mode, strr_rate, scyc, acks;
   bit rnd_en, reload, force_strr;
   int ack_id_q[$];
   int ack_cyc_q[$];

   task automatic drive();
      i_req = req_v;
      for (int n = 0; n < 4; n++) begin
         i_adrs[n*AW +: AW] = c_adrs[n];
         i_len[n*LW +: LW]  = c_len[n];
      end
   endtask

   task automatic new_cmd(input int n, input logic [AW-1:0] a, input int len);
      req_v[n]  = 1'b1;
      c_adrs[n] = a;
      c_len[n]  = LW'(len);
   endtask

   // One clock: sample accepts on the falling edge, update inputs after the
   // rising edge.
   task automatic cycle();
      logic [3:0] ack_c;
      logic       oreq_c;
      @(negedge clk_core);
      ack_c  = o_ack;
      oreq_c = o_req;
      @(posedge clk_core);
      #1;
      for (int n = 0; n < 4; n++) begin
         if (ack_c[n]) begin
            acks++;
            ack_id_q.push_back(n);
            ack_cyc_q.push_back(scyc);
            owed += int'(c_len[n]);
            req_v[n] = reload;
         end
      end
      scyc++;
      if (rnd_en)
         for (int n = 0; n < 4; n++)
            if (!req_v[n] && $urandom_range(0, 99) < 30)
               new_cmd(n, AW'($urandom), $urandom_range(1, 8));
      case (ack_mode)
         0:       i_ack = 1'b0;
         1:       i_ack = 1'b1;
         2:       i_ack = oreq_c;
         default: i_ack = 1'($urandom_range(0, 1));
      endcase
      if (force_strr) begin
         i_strr     = 1'b1;
         force_strr = 1'b0;
      end else if (owed > 0 && $urandom_range(0, 99) < strr_rate) begin
         i_strr = 1'b1;
         owed--;
      end else begin
         i_strr = 1'b0;
      end
      i_dbr = DW'($urandom);
      drive();
   endtask

   task automatic do_reset();
      rst_x    = 1'b1;
      req_v    = '0;
      owed     = 0;
      ack_mode = 0;
      reload   = 1'b0;
      drive();
      repeat (2) cycle();
      rst_x = 1'b0;
      acks  = 0;
      ack_id_q.delete();
      ack_cyc_q.delete();
   endtask

   task automatic wait_acks(input int n, input int budget, input string nm);
      int k = 0;
      while (acks < n && k < budget) begin cycle(); k++; end
      chk(nm, 64'(acks >= n), 1);
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int k = 0;
      while ((req_v != 0 || owed > 0) && k < budget) begin cycle(); k++; end
      repeat (3) cycle();
      chk(nm, 64'(req_v == 0 && owed == 0), 1);
   endtask

   // ---------------- monitor / reference model ----------------
   initial begin : mon
      int         m_ptr, cur_g, m_out, g, l, e;
      bit         err_m, oreq_prev;
      logic [3:0] req_prev, exp_v;
      int         beatq[$];
      m_ptr = 0; cur_g = 0; m_out = 0; err_m = 0; oreq_prev = 0; req_prev = '0;
      forever begin
         @(negedge clk_core);
         if (rst_x) begin
            m_ptr = 0; cur_g = 0; m_out = 0; err_m = 0; oreq_prev = 0;
            req_prev = i_req;
            beatq.delete();
            continue;
         end
         chk("o_err", o_err, err_m);
         if (m_out >= DEPTH) chk("full_blocks_req", o_req, 0);
         if (o_req && !oreq_prev) begin
            g = rr_ref(req_prev, m_ptr);
            chk("grant_has_req", 64'(g >= 0), 1);
            cur_g = (g < 0) ? 0 : g;
         end
         if (o_req) begin
            chk("o_adrs", o_adrs, i_adrs[cur_g*AW +: AW]);
            chk("o_len", o_len, i_len[cur_g*LW +: LW]);
         end
         exp_v = (o_req && i_ack) ? (4'b0001 << cur_g) : 4'b0000;
         chk("o_ack", o_ack, exp_v);
         if (o_req && i_ack) begin
            l = int'(i_len[cur_g*LW +: LW]);
            for (int b = 0; b < l; b++) beatq.push_back(cur_g*2 + ((b == l-1) ? 1 : 0));
            if (l > 0) m_out++;
            m_ptr = (cur_g + 1) % 4;
         end
         if (i_strr) begin
            if (beatq.size() > 0) begin
               e = beatq.pop_front();
               exp_v = 4'b0001 << (e / 2);
               chk("o_strr", o_strr, exp_v);
               chk("o_dbr", o_dbr, i_dbr);
               if (e % 2 == 1) m_out--;
            end else begin
               chk("o_strr_empty", o_strr, 0);
               err_m = 1;
            end
         end else begin
            chk("o_strr_idle", o_strr, 0);
         end
         oreq_prev = o_req;
         req_prev  = i_req;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      int exp_ord [5];
      int start, k;
      exp_ord = '{0, 1, 2, 3, 0};
      req_v = '0; owed = 0; ack_mode = 0; strr_rate = 0; scyc = 0; acks = 0;
      rnd_en = 0; reload = 0; force_strr = 0;
      for (int n = 0; n < 4; n++) begin c_adrs[n] = '0; c_len[n] = '0; end
      i_ack = 0; i_strr = 0; i_dbr = '0;
      drive();
      do_reset();
      chk("rst_o_req", o_req, 0);
      chk("rst_o_ack", o_ack, 0);
      chk("rst_o_strr", o_strr, 0);
      chk("rst_o_err", o_err, 0);

      // Single requester 2, accept one cycle after o_req, 16 beats.
      ack_mode = 2;
      new_cmd(2, 32'h100, 16);
      drive();
      wait_acks(1, 20, "t1_ack_timeout");
      repeat (3) cycle();
      chk("t1_ack_count", acks, 1);
      strr_rate = 100;
      wait_idle(40, "t1_drain");

      // All four held, immediate accept: order 0,1,2,3,0 two cycles apart.
      do_reset();
      ack_mode = 1; reload = 1; strr_rate = 100;
      for (int n = 0; n < 4; n++) new_cmd(n, AW'($urandom), 1);
      drive();
      wait_acks(5, 40, "t2_ack_timeout");
      reload = 0;
      if (ack_id_q.size() >= 5)
         for (int i = 0; i < 5; i++) begin
            chk("t2_order", ack_id_q[i], exp_ord[i]);
            if (i > 0) chk("t2_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], 2);
         end
      wait_idle(60, "t2_drain");

      // Five commands, no data: the fifth waits for the first burst's pop.
      do_reset();
      ack_mode = 1; strr_rate = 0;
      for (int n = 0; n < 4; n++) new_cmd(n, AW'($urandom), 2);
      drive();
      wait_acks(4, 30, "t3_four_timeout");
      new_cmd(0, AW'($urandom), 2);
      drive();
      repeat (8) cycle();
      chk("t3_fifth_blocked", acks, 4);
      strr_rate = 100;
      start = scyc;
      wait_acks(5, 10, "t3_fifth_timeout");
      chk("t3_fifth_latency", 64'(scyc - start <= 6), 1);
      wait_idle(60, "t3_drain");

      // Interleaved owners: req1 len 3, req3 len 2, then 5 beats.
      strr_rate = 0; acks = 0;
      new_cmd(1, AW'($urandom), 3); drive();
      wait_acks(1, 20, "t4_a_timeout");
      new_cmd(3, AW'($urandom), 2); drive();
      wait_acks(2, 20, "t4_b_timeout");
      chk("t4_owed", owed, 5);
      strr_rate = 100;
      wait_idle(40, "t4_drain");

      // Zero-length command pops without a beat.
      strr_rate = 0; acks = 0;
      new_cmd(0, AW'($urandom), 0); drive();
      wait_acks(1, 20, "t5_a_timeout");
      new_cmd(1, AW'($urandom), 1); drive();
      wait_acks(2, 20, "t5_b_timeout");
      repeat (4) cycle();
      strr_rate = 100;
      wait_idle(20, "t5_drain");

      // Randomized traffic.
      rnd_en = 1; ack_mode = 3;
      for (int blk = 0; blk < 8; blk++) begin
         strr_rate = $urandom_range(10, 100);
         repeat (100) cycle();
      end
      rnd_en = 0; ack_mode = 1; strr_rate = 100;
      wait_idle(400, "rnd_drain");

      // Beat with nothing outstanding.
      force_strr = 1;
      cycle();
      cycle();
      chk("err_set", o_err, 1);

      // Reset in the middle of a grant.
      ack_mode = 0;
      new_cmd(2, AW'($urandom), 4); drive();
      k = 0;
      while (!o_req && k < 5) begin cycle(); k++; end
      chk("t6_granted", o_req, 1);
      rst_x = 1; req_v = '0; owed = 0; drive();
      cycle();
      rst_x = 0;
      chk("t6_oreq_after_rst", o_req, 0);
      chk("t6_err_after_rst", o_err, 0);
      force_strr = 1;
      cycle();
      cycle();
      chk("t6_beat_after_rst_err", o_err, 1);
      repeat (2) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/fm_rd_arb.md
# fm_rd_arb

Four-port read-command arbiter placed in front of the shared DRAM read path, upstream of the burst splitter. It grants one requester at a time using round-robin arbitration and holds the grant until the downstream port accepts the command. It records the owner and length of every accepted command in an outstanding-command FIFO. Returning read beats are steered back to the owning requester in command order.

## Interface
Parameters:
- P_IB_ADDR_WIDTH, from polyphony_params: command address width.
- P_IB_LEN_WIDTH, from polyphony_params: burst length width.
- P_IB_DATA_WIDTH, from polyphony_params: read data width.
- P_OUT_DEPTH, default 4: outstanding-command FIFO depth (power of 2, at least 2).

Ports:
- clk_core  in  1  core clock; one clock domain only.
- rst_x  in  1  reset; synchronous and active-high.
- i_req  in  4  per-requester command request.
- i_adrs  in  4*P_IB_ADDR_WIDTH  per-requester address; requester n uses slice n.
- i_len  in  4*P_IB_LEN_WIDTH  per-requester burst length; requester n uses slice n.
- o_ack  out  4  per-requester command accept.
- o_req  out  1  downstream command request.
- o_adrs  out  P_IB_ADDR_WIDTH  downstream address.
- o_len  out  P_IB_LEN_WIDTH  downstream length.
- i_ack  in  1  downstream command accept.
- i_strr  in  1  downstream read-data strobe.
- i_dbr  in  P_IB_DATA_WIDTH  downstream read data.
- o_strr  out  4  per-requester read-data strobe.
- o_dbr  out  P_IB_DATA_WIDTH  read data, broadcast to all requesters.
- o_err  out  1  sticky protocol-error flag.

## Operation
- State machine has two states, P_IDLE and P_GRANT.
- P_IDLE:
  - If any i_req bit is set and the FIFO is not full, select a requester round-robin.
  - Search starts at r_ptr and wraps 3 -> 0.
  - Register the grant id, then go to P_GRANT.
- P_GRANT:
  - o_req = i_req[grant] & !fifo_full.
  - o_adrs and o_len are the granted slices, passed through combinationally.
  - o_ack[grant] = o_req & i_ack; all other o_ack bits are 0.
  - On o_req & i_ack:
    - Push {grant, o_len} into the FIFO.
    - Set r_ptr = grant+1 mod 4.
    - Return to P_IDLE.
  - If i_req[grant] drops before it is acknowledged, return to P_IDLE without pushing (requester withdrew).
- FIFO push is blocked whenever the FIFO is full. A pop in the same cycle does not unblock the push; the push happens the next cycle.
- Return path:
  - The beat counter loads the head entry's len when the head becomes valid.
  - o_strr[head.id] = i_strr & fifo_not_empty; o_dbr = i_dbr.
  - Each i_strr decrements the counter. The beat with counter==1 pops the head.
  - A head entry with len==0 pops one cycle after it becomes head and consumes no beat.
- Push and pop in the same cycle are legal when the FIFO is neither full nor empty: occupancy is unchanged and the pointers advance.
- Error: i_strr while the FIFO is empty sets o_err. The beat is dropped (o_strr = 0). o_err clears only on reset.

## Timing
- Reset values:
  - State P_IDLE, r_ptr 0, FIFO empty, counter 0, o_err 0.
  - o_req 0, o_ack 0, o_strr 0.
  - o_adrs and o_len are don't-care while o_req = 0.
- Command latency: i_req rising in cycle t gives o_req in cycle t+1 at the earliest. o_ack is combinational from i_ack in the cycle of acceptance.
- Minimum spacing between accepted commands is 2 cycles (an idle arbitration cycle between grants).
- Requesters hold i_req, i_adrs and i_len stable until their o_ack.
- Return strobe and data have zero latency (combinational steering).
- Reset during an active grant or with beats outstanding abandons everything. Beats arriving after reset raise o_err.

## Structure
- The outstanding-command FIFO is its own sub-module, fm_rd_arb_fifo: synchronous single-clock FIFO, entry {id[1:0], len}, with full/empty outputs and P_OUT_DEPTH as a parameter.
- Add P_ARB_IDLE and P_ARB_GRANT, and the requester count 4, to polyphony_params.v.
- The round-robin picker and beat counter stay in fm_rd_arb.

## Test plan
- Single requester 2, adrs 0x100, len 16, i_ack one cycle after o_req -> o_ack[2] pulses once; 16 i_strr beats -> o_strr[2] pulses 16 times; FIFO returns to empty.
- All four i_req held, immediate i_ack -> grant order 0, 1, 2, 3, 0, each accepted command 2 cycles apart; o_ack is one-hot in every cycle.
- P_OUT_DEPTH=4, five commands accepted with no returned data -> the fifth command's o_req stays 0 until the first beat burst completes its pop, then it is accepted the following cycle.
- Interleaved commands: req1 len 3, then req3 len 2, then 5 beats -> o_strr[1] pulses 3 times, then o_strr[3] pulses 2 times; no strobe goes to the wrong requester.
- Command with len 0 from requester 0, followed by len 1 from requester 1 -> the len 0 entry pops without a beat; the first i_strr goes to o_strr[1].
- i_strr with the FIFO empty -> o_err = 1 and o_strr = 0. Assert rst_x mid-grant -> o_req = 0 and o_err = 0 on the next cycle.
